// File: rtl/ones_gen_pkg.sv
// Shared state encoding and default widths for the ones-pattern generator.
package ones_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam int NBITS_DEF       = 8;
  localparam int NOUTPUTBITS_DEF = 4;
  localparam int DIV_W_DEF       = 25;

endpackage

// File: rtl/ones_pattern_gen_tick_divider.sv
// Free-running DIV_W-bit divider; tick is high for the one clock the count is all-ones.
// Latency: first tick 2^DIV_W clocks after reset release; no backpressure.
module tick_divider #(
  parameter int DIV_W = 25
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  logic [DIV_W-1:0] divider;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) divider <= '0;
    else       divider <= divider + 1'b1;
  end

  assign tick = &divider;

endmodule

// File: rtl/ones_pattern_gen.sv
// Builds an nBits word holding exactly `count` ones (MSB-aligned), one bit per tick; nBits ticks per word.
// No backpressure: start is only sampled outside SHIFT. ONES_GEN_CLK_DIV_EN enables the tick divider.
module ones_pattern_gen
  import ones_gen_pkg::*;
#(
  parameter int nBits       = NBITS_DEF,
  parameter int nOutputBits = NOUTPUTBITS_DEF,
  parameter int DIV_W       = DIV_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [nOutputBits-1:0] count,
  output logic [nBits-1:0]       outData,
  output logic                   serialOut,
  output logic                   busy,
  output logic                   ready,
  output logic                   error
);

  localparam int IDX_W = (nBits > 1) ? $clog2(nBits) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(nBits - 1);

  if (DIV_W < 1) begin : g_bad_div_w
    $error("ones_pattern_gen: DIV_W must be at least 1");
  end

  state_t                 state;
  logic [nOutputBits-1:0] remaining;
  logic [IDX_W-1:0]       bitIdx;
  logic                   tick;
  logic                   ins;

`ifdef ONES_GEN_CLK_DIV_EN
  tick_divider #(.DIV_W(DIV_W)) u_tick_divider (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign ins = (remaining != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      outData   <= '0;
      serialOut <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      error     <= 1'b0;
      remaining <= '0;
      bitIdx    <= '0;
    end else if (tick) begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            outData <= '0;
            // Unsigned compare at a common width so any count/nBits combination is safe.
            if (32'(count) > 32'(nBits)) begin
              state <= ERROR;
              error <= 1'b1;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= SHIFT;
              remaining <= count;
              bitIdx    <= '0;
              busy      <= 1'b1;
              ready     <= 1'b0;
              error     <= 1'b0;
            end
          end
        end
        SHIFT: begin
          outData   <= {outData[nBits-2:0], ins};
          serialOut <= ins;
          if (ins) remaining <= remaining - 1'b1;
          // bitIdx parks at its terminal value instead of wrapping.
          if (bitIdx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end else begin
            bitIdx <= bitIdx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed and randomized checks of ones_pattern_gen with tick on every clock.
module tb_ones_pattern_gen;

  localparam int NB = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    count;
  logic [NB-1:0] outData;
  logic          serialOut;
  logic          busy;
  logic          ready;
  logic          error;

  int checks   = 0;
  int failures = 0;

  ones_pattern_gen dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .outData   (outData),
    .serialOut (serialOut),
    .busy      (busy),
    .ready     (ready),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word after k steps of a count-n build: the first min(n,k) inserted bits are ones.
  function automatic logic [31:0] partial_word(input int n, input int k);
    int m;
    m = (n < k) ? n : k;
    return 32'(((1 << m) - 1) << (k - m)) & 32'hFF;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Start a build of count n; with noise, start/count are scrambled while shifting.
  task automatic run_op(input int n, input bit noise);
    start = 1'b1;
    count = 4'(n);
    step();
    start = 1'b0;
    if (n > NB) begin
      check("err_error", 32'(error), 1);
      check("err_ready", 32'(ready), 1);
      check("err_busy", 32'(busy), 0);
      check("err_data", 32'(outData), 0);
      step();
      check("err_hold_busy", 32'(busy), 0);
      check("err_hold_error", 32'(error), 1);
      return;
    end
    check("acc_busy", 32'(busy), 1);
    check("acc_ready", 32'(ready), 0);
    check("acc_error", 32'(error), 0);
    check("acc_data", 32'(outData), 0);
    for (int k = 1; k <= NB; k++) begin
      if (noise && k > 1 && k < NB) begin
        start = 1'($urandom_range(0, 1));
        count = 4'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      step();
      check($sformatf("n%0d_k%0d_data", n, k), 32'(outData), partial_word(n, k));
      check($sformatf("n%0d_k%0d_ser", n, k), 32'(serialOut), (k <= n) ? 1 : 0);
      check($sformatf("n%0d_k%0d_busy", n, k), 32'(busy), (k < NB) ? 1 : 0);
      check($sformatf("n%0d_k%0d_ready", n, k), 32'(ready), (k == NB) ? 1 : 0);
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    count = 4'd0;
    #12;
    check("rst_data", 32'(outData), 0);
    check("rst_ser", 32'(serialOut), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_error", 32'(error), 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    step();
    check("idle_hold_ready", 32'(ready), 0);
    check("idle_hold_busy", 32'(busy), 0);

    // Typical, boundaries, error, then recovery out of ERROR.
    run_op(3, 1'b0);
    check("typ_word", 32'(outData), 32'hE0);
    run_op(0, 1'b0);
    check("zero_word", 32'(outData), 32'h00);
    check("zero_error", 32'(error), 0);
    run_op(8, 1'b0);
    check("full_word", 32'(outData), 32'hFF);
    run_op(12, 1'b0);
    run_op(9, 1'b0);
    run_op(2, 1'b1);
    check("ignored_word", 32'(outData), 32'hC0);

    // Restart straight from DONE.
    run_op(1, 1'b0);
    check("restart_word", 32'(outData), 32'h80);

    // Reset in the middle of a build.
    start = 1'b1;
    count = 4'd5;
    step();
    start = 1'b0;
    repeat (4) step();
    check("mid_partial", 32'(outData), partial_word(5, 4));
    reset = 1'b1;
    #1;
    check("mid_rst_data", 32'(outData), 0);
    check("mid_rst_ser", 32'(serialOut), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(ready), 0);
    check("mid_rst_error", 32'(error), 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 0);
    run_op(5, 1'b0);
    check("post_rst_word", 32'(outData), 32'hF8);

    // Randomized builds, with occasional input scrambling during SHIFT.
    for (int r = 0; r < 24; r++) begin
      run_op(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ones_pattern_gen.md
# ones_pattern_gen

Sequential generator that is the inverse of the bit-counting path. It takes a 4-bit target count N and builds an nBits-wide word containing exactly N ones, one bit per step. The word is shifted in serially, and the inserted bit is also presented on a serial output. It sits beside the counter and display path and produces test words for the counting datapath, or feeds a downstream serial consumer. Steps are paced by a low-frequency tick derived from the board clock.

## Interface
- nBits, 8, width of the generated word
- nOutputBits, 4, width of the count input
- DIV_W, 25, clock-divider width; one step tick per 2^DIV_W clocks
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request to build a word; sampled only on a step tick
- count  input  nOutputBits  target number of ones N; latched when start is accepted
- outData  output  nBits  word under construction / finished word
- serialOut  output  1  bit inserted on the most recent step
- busy  output  1  high while in SHIFT
- ready  output  1  high in DONE and ERROR
- error  output  1  high in ERROR (N > nBits)

## Operation
- The FSM has four states: IDLE, SHIFT, DONE and ERROR. It advances only on edges where tick=1.
- **Reset:** state=IDLE; outData=0, serialOut=0, busy=0, ready=0, error=0; remaining=0; bitIdx=0; divider=0.
- **IDLE/DONE/ERROR with start=1:**
  - If count > nBits, go to ERROR. Set outData=0, error=1, ready=1.
  - Otherwise go to SHIFT. Set outData=0, remaining=count, bitIdx=0, busy=1, ready=0, error=0.
- **IDLE/DONE/ERROR with start=0:** hold all state and outputs.
- **SHIFT, each tick:**
  - ins = (remaining != 0).
  - outData <= {outData[nBits-2:0], ins}.
  - serialOut <= ins.
  - If ins, decrement remaining.
  - Increment bitIdx.
  - When bitIdx == nBits-1 on this tick, go to DONE with busy=0 and ready=1.
- **start during SHIFT:** ignored; count changes are ignored as well.
- **Result:** the ones end up MSB-aligned. N=3, nBits=8 gives 8'b1110_0000.
- **Width rules:**
  - remaining is nOutputBits wide and never underflows.
  - bitIdx is $clog2(nBits) wide; its terminal value is nBits-1, with no wrap.
  - The count comparison is unsigned.

## Timing
- The tick is high for one clock when the divider reaches all-ones. The divider wraps to 0.
- Let t0 be the tick on which start is accepted. The SHIFT steps occur at ticks t1..t_nBits.
- ready rises at the clock edge of tick t_nBits, which is nBits ticks after t0.
- ERROR is entered at t0 itself; ready and error are valid after that edge.
- serialOut changes only on SHIFT ticks; it holds the last inserted bit afterward.
- **Back-to-back operation:** start held high in DONE restarts on the next tick. ready falls at that edge.
- **Reset mid-operation:** the clear is asynchronous. No partial word survives. After reset is released, the first tick occurs 2^DIV_W clocks later.

## Configuration
- Macro: ONES_GEN_CLK_DIV_EN.
- **Defined:** the internal DIV_W-bit divider produces the tick (hardware pacing for visual observation).
- **Undefined:**
  - tick=1 on every clock and the divider is not instantiated; used in simulation.
  - DIV_W is ignored.
  - All cycle counts above apply with ticks equal to clocks.

## Structure
- Package ones_gen_pkg holds:
  - the state encoding typedef: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2, ERROR=2'd3;
  - the default width constants.
- Sub-module tick_divider (DIV_W parameter; clock/reset in, tick out) is instantiated only under ONES_GEN_CLK_DIV_EN.
- FSM, counters and shift register live in ones_pattern_gen.

## Test plan
All scenarios are built without the macro, so tick = every clock.
- **Typical count:** count=3, start pulse -> outData=8'hE0 and ready=1 exactly 8 clocks after acceptance; serialOut sequence 1,1,1,0,0,0,0,0; busy=1 throughout.
- **Boundaries:** count=0 -> outData=8'h00, error=0. count=8 -> outData=8'hFF, ready after 8 clocks.
- **Error:** count=12, start -> next edge error=1, ready=1, outData=0, busy=0; no SHIFT is entered.
- **Reset mid-operation:** count=5 start, assert reset after 4 shifts -> all outputs 0 immediately. Release reset, count=5 start -> outData=8'hF8 after 8 clocks.
- **Ignored inputs:** during SHIFT, toggle start and change count to 7 -> result still matches the originally latched count (count=2 -> 8'hC0).
- **Restart:** start held high in DONE with count=1 -> ready drops on the next edge; 8'h80 after 8 more clocks.
